// File: rtl/alu_sched_arbiter_pkg.sv
// Shared types and constants for the ALU scheduler/arbiter.
// Contents: FSM state enum, ALU op codes, packed operation layout,
// field slice positions, and the data widths used on the request/response paths.
package alu_arb_pkg;

    localparam int unsigned RES_W  = 9;
    localparam int unsigned OP_W   = 10;
    localparam int unsigned DATA_W = 4;

    localparam int unsigned DATA1_LSB = 0;
    localparam int unsigned DATA1_MSB = 3;
    localparam int unsigned DATA2_LSB = 4;
    localparam int unsigned DATA2_MSB = 7;
    localparam int unsigned OPC_LSB   = 8;
    localparam int unsigned OPC_MSB   = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } opcode_e;

    // Bit order matches the wire packing: op [9:8], data2 [7:4], data1 [3:0].
    typedef struct packed {
        opcode_e             op;
        logic [DATA_W-1:0]   data2;
        logic [DATA_W-1:0]   data1;
    } alu_op_t;

    // Split a raw packed word into its fields.
    function automatic alu_op_t unpack_op(input logic [OP_W-1:0] raw);
        alu_op_t o;
        o.op    = opcode_e'(raw[OPC_MSB:OPC_LSB]);
        o.data2 = raw[DATA2_MSB:DATA2_LSB];
        o.data1 = raw[DATA1_MSB:DATA1_LSB];
        return o;
    endfunction

    // Division by zero is answered locally and never reaches the ALU.
    function automatic logic is_div_zero(input alu_op_t o);
        return (o.op == OP_DIV) && (o.data2 == '0);
    endfunction

endpackage

// File: rtl/alu_sched_arbiter_if.sv
// Requester / ALU / response bundle for the ALU scheduler.
// slave  : arbiter view (consumes requests, drives ALU issue and responses).
// master : environment view (requesters, ALU and response consumers).
interface alu_sched_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    import alu_arb_pkg::*;

    localparam int unsigned IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*OP_W-1:0] req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    alu_valid;
    logic [OP_W-1:0]         alu_data;
    logic                    alu_ready;
    logic                    alu_done;
    logic [RES_W-1:0]        alu_result;
    logic [NUM_REQ-1:0]      rsp_valid;
    logic [RES_W-1:0]        rsp_data;
    logic                    rsp_err;
    logic [NUM_REQ-1:0]      rsp_ready;
    logic                    busy;
    logic [IDW-1:0]          grant_id;

    modport slave (
        input  req_valid, req_data, alu_ready, alu_done, alu_result, rsp_ready,
        output req_ready, alu_valid, alu_data, rsp_valid, rsp_data, rsp_err, busy, grant_id
    );

    modport master (
        output req_valid, req_data, alu_ready, alu_done, alu_result, rsp_ready,
        input  req_ready, alu_valid, alu_data, rsp_valid, rsp_data, rsp_err, busy, grant_id
    );

endinterface

// File: rtl/alu_sched_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_grant, wrapping.
// Ports: req_i (request vector), last_grant_i (previous owner),
//        win_oh_o (one-hot winner), win_idx_o (winner index), any_o (any request set).
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     last_grant_i,
    output logic [NUM_REQ-1:0] win_oh_o,
    output logic [IDW-1:0]     win_idx_o,
    output logic               any_o
);

    // Walk candidates last+1 .. last+NUM_REQ; the first hit wins.
    always_comb begin
        int unsigned cand;
        win_oh_o  = '0;
        win_idx_o = '0;
        any_o     = 1'b0;
        cand      = 0;
        for (int unsigned off = 1; off <= NUM_REQ; off++) begin
            cand = (32'(last_grant_i) + off) % NUM_REQ;
            if (!any_o && req_i[IDW'(cand)]) begin
                any_o                   = 1'b1;
                win_idx_o               = IDW'(cand);
                win_oh_o[IDW'(cand)]    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_sched_arbiter.sv
// Round-robin scheduler sharing one multi-cycle ALU among NUM_REQ requesters.
// Ports: clk, reset (synchronous, active-low), bus (slave view of the
// request / ALU / response bundle). req_ready is combinational; all other
// outputs are registered.
module alu_sched_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    alu_sched_arbiter_if.slave bus
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned TW  = $clog2(TIMEOUT);

    state_e              state_q;
    logic [IDW-1:0]      last_grant_q;
    logic [IDW-1:0]      grant_q;
    alu_op_t             op_q;
    logic [RES_W-1:0]    res_q;
    logic                err_q;
    logic [TW-1:0]       timer_q;
    logic                alu_valid_q;
    logic [NUM_REQ-1:0]  rsp_valid_q;
    logic                busy_q;

    logic [NUM_REQ-1:0]  win_oh_c;
    logic [IDW-1:0]      win_idx_c;
    logic                any_c;
    alu_op_t             req_ops_c [NUM_REQ];
    alu_op_t             win_op_c;

    // Unpack each requester's slot of the flat request bus.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_ops_c[g] = unpack_op(bus.req_data[g*OP_W +: OP_W]);
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i        (bus.req_valid),
        .last_grant_i (last_grant_q),
        .win_oh_o     (win_oh_c),
        .win_idx_o    (win_idx_c),
        .any_o        (any_c)
    );

    assign win_op_c = req_ops_c[win_idx_c];

    // Accept pulse only while idle and out of reset.
    assign bus.req_ready  = (reset && (state_q == ST_IDLE)) ? win_oh_c : '0;
    assign bus.alu_valid  = alu_valid_q;
    assign bus.alu_data   = op_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_data   = res_q;
    assign bus.rsp_err    = err_q;
    assign bus.busy       = busy_q;
    assign bus.grant_id   = grant_q;

    // Scheduler FSM with operation/result latches and the WAIT watchdog.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDW'(NUM_REQ - 1);
            grant_q      <= '0;
            op_q         <= '0;
            res_q        <= '0;
            err_q        <= 1'b0;
            timer_q      <= '0;
            alu_valid_q  <= 1'b0;
            rsp_valid_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_c) begin
                        grant_q <= win_idx_c;
                        op_q    <= win_op_c;
                        busy_q  <= 1'b1;
                        if (is_div_zero(win_op_c)) begin
                            res_q       <= '0;
                            err_q       <= 1'b1;
                            rsp_valid_q <= win_oh_c;
                            state_q     <= ST_RESP;
                        end else begin
                            alu_valid_q <= 1'b1;
                            state_q     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (bus.alu_ready) begin
                        alu_valid_q <= 1'b0;
                        timer_q     <= '0;
                        state_q     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A completion in the final watchdog cycle still counts as success.
                    if (bus.alu_done) begin
                        res_q       <= bus.alu_result;
                        err_q       <= 1'b0;
                        rsp_valid_q <= NUM_REQ'(1) << grant_q;
                        state_q     <= ST_RESP;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        res_q       <= '0;
                        err_q       <= 1'b1;
                        rsp_valid_q <= NUM_REQ'(1) << grant_q;
                        state_q     <= ST_RESP;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready[grant_q]) begin
                        rsp_valid_q  <= '0;
                        last_grant_q <= grant_q;
                        busy_q       <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sched_arbiter.sv
// Self-checking bench for alu_sched_arbiter: directed vector table,
// hand-written corner sequences, and randomized traffic against a reference model.
module tb_alu_sched_arbiter;
    import alu_arb_pkg::*;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned TIMEOUT = 15;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alu_sched_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

    alu_sched_arbiter #(
        .NUM_REQ (NUM_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int last_m;

    typedef struct {
        logic [3:0]  mask;
        logic [39:0] data;
        int          rdy;
        int          done_at;
        int          rspd;
        int          exp_w;
        logic [8:0]  exp_data;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: the valid requester closest after the last owner, cyclically.
    function automatic int rr_model(input logic [3:0] mask, input int last);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mask[i]) begin
                d = (i - last - 1 + 2 * NUM_REQ) % NUM_REQ;
                if (d < bestd) begin
                    bestd = d;
                    best  = i;
                end
            end
        end
        return best;
    endfunction

    // Behavioural ALU: what a correct ALU returns for a packed operation.
    function automatic logic [8:0] alu_model(input logic [9:0] opw);
        int a;
        int b;
        int r;
        a = int'(opw[3:0]);
        b = int'(opw[7:4]);
        case (opw[9:8])
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a * b;
            default: r = (b == 0) ? 0 : a / b;
        endcase
        return 9'(r);
    endfunction

    task automatic clear_inputs();
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.alu_ready  = 1'b0;
        bus.alu_done   = 1'b0;
        bus.alu_result = '0;
        bus.rsp_ready  = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " req_ready"}, bus.req_ready, 0);
        chk({tag, " alu_valid"}, bus.alu_valid, 0);
        chk({tag, " alu_data"},  bus.alu_data, 0);
        chk({tag, " rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, " rsp_data"},  bus.rsp_data, 0);
        chk({tag, " rsp_err"},   bus.rsp_err, 0);
        chk({tag, " busy"},      bus.busy, 0);
        chk({tag, " grant_id"},  bus.grant_id, 0);
    endtask

    // One full transaction, cycle-exact: accept, issue (rdy stall cycles),
    // WAIT (done on WAIT cycle done_at, 0 = withheld), RESP (rspd backpressure cycles).
    // Returns right after driving the owner's rsp_ready; the next negedge is IDLE.
    task automatic run_txn(input logic [3:0] mask, input logic [39:0] data,
                           input int rdy, input int done_at, input int rspd,
                           input int exp_w, input logic [8:0] exp_data,
                           input logic exp_err, input string tag);
        logic [9:0] wop;
        logic       dz;
        logic [3:0] oh;
        logic [8:0] alu_res;
        wop = data[exp_w*10 +: 10];
        dz  = (wop[9:8] == 2'd3) && (wop[7:4] == 4'd0);
        oh  = '0;
        oh[exp_w] = 1'b1;

        @(negedge clk);
        bus.req_valid = mask;
        bus.req_data  = data;
        bus.rsp_ready = '0;
        bus.alu_done  = 1'b0;
        bus.alu_ready = 1'b0;
        #1;
        chk({tag, " idle busy"}, bus.busy, 0);
        chk({tag, " idle rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, " req_ready"}, bus.req_ready, oh);

        @(negedge clk);
        bus.req_valid = 4'($urandom);
        bus.req_data  = {8'($urandom), 32'($urandom)};
        #1;
        chk({tag, " grant_id"}, bus.grant_id, exp_w);
        chk({tag, " busy"}, bus.busy, 1);
        chk({tag, " req_ready busy"}, bus.req_ready, 0);
        if (dz) begin
            chk({tag, " dz alu_valid"}, bus.alu_valid, 0);
        end else begin
            chk({tag, " alu_valid"}, bus.alu_valid, 1);
            chk({tag, " alu_data"}, bus.alu_data, wop);
            for (int i = 0; i < rdy; i++) begin
                bus.alu_done = 1'($urandom_range(0, 1));
                @(negedge clk);
                #1;
                chk({tag, " stall alu_valid"}, bus.alu_valid, 1);
                chk({tag, " stall alu_data"}, bus.alu_data, wop);
            end
            bus.alu_ready = 1'b1;
            bus.alu_done  = 1'b0;
            alu_res = alu_model(bus.alu_data);
            for (int c = 1; c <= int'(TIMEOUT); c++) begin
                @(negedge clk);
                bus.alu_ready = 1'($urandom_range(0, 1));
                if (c == done_at) begin
                    bus.alu_done   = 1'b1;
                    bus.alu_result = alu_res;
                end else begin
                    bus.alu_done   = 1'b0;
                    bus.alu_result = 9'($urandom);
                end
                #1;
                chk({tag, " wait alu_valid"}, bus.alu_valid, 0);
                chk({tag, " wait rsp_valid"}, bus.rsp_valid, 0);
                if (c == done_at) break;
            end
            @(negedge clk);
            bus.alu_done  = 1'b0;
            bus.alu_ready = 1'b0;
            #1;
        end

        chk({tag, " rsp_valid"}, bus.rsp_valid, oh);
        chk({tag, " rsp_data"}, bus.rsp_data, exp_data);
        chk({tag, " rsp_err"}, bus.rsp_err, exp_err);
        for (int i = 0; i < rspd; i++) begin
            bus.rsp_ready  = 4'($urandom) & ~oh;
            bus.alu_done   = 1'($urandom_range(0, 1));
            bus.alu_result = 9'($urandom);
            @(negedge clk);
            #1;
            chk({tag, " hold rsp_valid"}, bus.rsp_valid, oh);
            chk({tag, " hold rsp_data"}, bus.rsp_data, exp_data);
            chk({tag, " hold rsp_err"}, bus.rsp_err, exp_err);
            chk({tag, " hold req_ready"}, bus.req_ready, 0);
        end
        bus.rsp_ready = 4'($urandom) | oh;
        bus.alu_done  = 1'b0;
        bus.req_valid = '0;
        last_m = exp_w;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [39:0] d;
        logic [9:0]  wop;
        logic [3:0]  m;
        int          w;
        int          done_at;
        logic [8:0]  ed;
        logic        ee;

        vecs[0]  = '{4'hF, {4{10'h043}}, 0, 1, 0, 0, 9'd7, 1'b0};
        vecs[1]  = '{4'hF, {4{10'h043}}, 0, 1, 0, 1, 9'd7, 1'b0};
        vecs[2]  = '{4'hF, {4{10'h043}}, 1, 1, 1, 2, 9'd7, 1'b0};
        vecs[3]  = '{4'hF, {4{10'h043}}, 0, 2, 0, 3, 9'd7, 1'b0};
        vecs[4]  = '{4'hF, {4{10'h043}}, 2, 1, 0, 0, 9'd7, 1'b0};
        vecs[5]  = '{4'b0100, {10'h1AB, 10'h265, 10'h1AB, 10'h1AB}, 0, 2, 4, 2, 9'd30, 1'b0};
        vecs[6]  = '{4'b0010, {10'h1AB, 10'h1AB, 10'h309, 10'h1AB}, 0, 0, 2, 1, 9'd0, 1'b1};
        vecs[7]  = '{4'b1000, {10'h152, 10'h1AB, 10'h1AB, 10'h1AB}, 1, 0, 1, 3, 9'd0, 1'b1};
        vecs[8]  = '{4'b1000, {10'h152, 10'h1AB, 10'h1AB, 10'h1AB}, 0, 15, 0, 3, 9'h1FD, 1'b0};
        vecs[9]  = '{4'b1010, {10'h0C3, 10'h1AB, 10'h34C, 10'h1AB}, 3, 4, 2, 1, 9'd3, 1'b0};
        vecs[10] = '{4'b1001, {10'h2FF, 10'h1AB, 10'h1AB, 10'h0FF}, 0, 1, 0, 3, 9'd225, 1'b0};
        vecs[11] = '{4'b1001, {10'h2FF, 10'h1AB, 10'h1AB, 10'h0FF}, 0, 1, 0, 0, 9'd30, 1'b0};

        clear_inputs();
        reset = 1'b0;
        bus.req_valid = 4'hF;
        bus.req_data  = {4{10'h043}};
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        clear_inputs();
        reset  = 1'b1;
        last_m = NUM_REQ - 1;

        // Directed table: fairness, backpressure, div-by-zero, timeout, done-in-timeout-cycle.
        foreach (vecs[i]) begin
            run_txn(vecs[i].mask, vecs[i].data, vecs[i].rdy, vecs[i].done_at, vecs[i].rspd,
                    vecs[i].exp_w, vecs[i].exp_data, vecs[i].exp_err, $sformatf("vec%0d", i));
        end

        // Timeout, then a late alu_done while IDLE must change nothing.
        run_txn(4'b0010, {10'h1AB, 10'h1AB, 10'h043, 10'h1AB}, 0, 0, 0,
                1, 9'd0, 1'b1, "late");
        @(negedge clk);
        bus.rsp_ready  = '0;
        bus.alu_done   = 1'b1;
        bus.alu_result = 9'h155;
        #1;
        chk("late idle busy", bus.busy, 0);
        chk("late idle rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        bus.alu_done = 1'b0;
        #1;
        chk("late after busy", bus.busy, 0);
        chk("late after rsp_valid", bus.rsp_valid, 0);
        chk("late after rsp_data", bus.rsp_data, 0);
        chk("late after alu_valid", bus.alu_valid, 0);

        // Reset during WAIT drops the operation.
        @(negedge clk);
        bus.req_valid = 4'b0100;
        bus.req_data  = {10'h1AB, 10'h043, 10'h1AB, 10'h1AB};
        @(negedge clk);
        bus.req_valid = '0;
        #1;
        chk("rstmid alu_valid", bus.alu_valid, 1);
        chk("rstmid grant_id", bus.grant_id, 2);
        bus.alu_ready = 1'b1;
        @(negedge clk);
        bus.alu_ready = 1'b0;
        #1;
        chk("rstmid wait busy", bus.busy, 1);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check_reset_outputs("rstmid");
        reset          = 1'b1;
        bus.alu_done   = 1'b1;
        bus.alu_result = 9'h0AA;
        @(negedge clk);
        bus.alu_done = 1'b0;
        #1;
        chk("rstmid stale rsp_valid", bus.rsp_valid, 0);
        chk("rstmid stale busy", bus.busy, 0);
        last_m = NUM_REQ - 1;
        run_txn(4'hF, {4{10'h043}}, 0, 1, 0, 0, 9'd7, 1'b0, "rstmid first");

        // Randomized traffic against the reference model.
        for (int n = 0; n < 40; n++) begin
            m = 4'($urandom_range(1, 15));
            for (int i = 0; i < NUM_REQ; i++) d[i*10 +: 10] = 10'($urandom);
            w = rr_model(m, last_m);
            if ($urandom_range(0, 5) == 0) d[w*10 +: 10] = {2'd3, 4'd0, 4'($urandom)};
            wop = d[w*10 +: 10];
            done_at = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
            if (wop[9:8] == 2'd3 && wop[7:4] == 4'd0) begin
                ed = '0;
                ee = 1'b1;
            end else if (done_at == 0) begin
                ed = '0;
                ee = 1'b1;
            end else begin
                ed = alu_model(wop);
                ee = 1'b0;
            end
            run_txn(m, d, int'($urandom_range(0, 3)), done_at, int'($urandom_range(0, 3)),
                    w, ed, ee, $sformatf("rand%0d", n));
        end

        @(negedge clk);
        clear_inputs();
        #1;
        chk("final busy", bus.busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_sched_arbiter.md
# alu_sched_arbiter

Round-robin scheduler that shares one multi-cycle ALU among `NUM_REQ` requesters. It accepts one packed operation at a time from the winning requester and issues it to the ALU. It waits for completion under a watchdog, then returns the 9-bit result to the same requester with backpressure. It sits between the input-side FIFOs and the ALU, replacing the direct FIFO-to-ALU connection.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; must be at least 2.
- `TIMEOUT`, 15: maximum WAIT-state cycles before an operation is aborted; must be at least 2.

Ports:
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `reset`, in, 1: synchronous, active-low reset.
- `req_valid`, in, NUM_REQ: one request-valid bit per requester.
- `req_data`, in, NUM_REQ*10: requester i uses bits [10i+9:10i]. Packing is data1 [3:0], data2 [7:4], op [9:8].
- `req_ready`, out, NUM_REQ: one-hot accept pulse.
- `alu_valid`, out, 1: operation valid to the ALU.
- `alu_data`, out, 10: latched packed operation.
- `alu_ready`, in, 1: ALU accepts the operation.
- `alu_done`, in, 1: single-cycle pulse; `alu_result` is valid in that cycle.
- `alu_result`, in, 9: ALU result.
- `rsp_valid`, out, NUM_REQ: one-hot response valid.
- `rsp_data`, out, 9: response result, shared by all requesters.
- `rsp_err`, out, 1: qualifies `rsp_data`. 1 means timeout or divide-by-zero.
- `rsp_ready`, in, NUM_REQ: per-requester response accept.
- `busy`, out, 1: high whenever the state is not IDLE.
- `grant_id`, out, $clog2(NUM_REQ): index of the current owner.

## Operation
States: IDLE, ISSUE, WAIT, RESP.

- **IDLE**
  - Pick the first requester with `req_valid` set, searching from `last_grant+1` with wrap-around.
  - `req_ready[win]` is combinational and asserted in the same cycle.
  - Latch the data and `grant_id`, then go to ISSUE.
  - Exception: if op==3 and data2==0, set err=1 and result=0, and go directly to RESP. The ALU never sees the operation.
- **ISSUE**
  - Hold `alu_valid`=1 and `alu_data` stable until `alu_ready`=1.
  - On acceptance, clear the timer and go to WAIT.
- **WAIT**
  - On `alu_done`: latch `alu_result`, set err=0, go to RESP.
  - Otherwise the timer increments.
  - When the timer equals TIMEOUT-1 and `alu_done`=0: set err=1 and result=0, go to RESP.
- **RESP**
  - Hold `rsp_valid[grant_id]`, `rsp_data` and `rsp_err` stable until `rsp_ready[grant_id]`=1.
  - On acceptance, set `last_grant`=`grant_id` and go to IDLE.
- **Ignored inputs**
  - `rsp_ready` bits of non-owners are ignored.
  - `alu_done` outside WAIT is ignored; no state or result change.
  - `req_valid` outside IDLE is ignored; all `req_ready` bits are 0.
- **Widths**
  - Results pass through unmodified at 9 bits.
  - The timer is $clog2(TIMEOUT) bits and never wraps.

## Timing
- **Reset** (`reset`=0 at a clock edge), regardless of current state:
  - State goes to IDLE. Any in-flight operation is dropped and no response is produced.
  - `last_grant`=NUM_REQ-1, so requester 0 wins first.
  - Outputs: `req_ready`=0, `alu_valid`=0, `alu_data`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `busy`=0, `grant_id`=0.
- **Latency**
  - Accept at cycle T; `alu_valid` at T+1.
  - With `alu_ready` at T+1 and `alu_done` at T+1+k: `rsp_valid` at T+2+k.
  - Minimum accept-to-response latency is 3 cycles (k=1).
  - Next accept is no earlier than the cycle after the response handshake.
- **Occupancy:** exactly one operation is outstanding at any time.
- **Simultaneous events**
  - `alu_done` in the timeout cycle: `alu_done` wins, err=0.
  - Multiple `req_valid` bits set: round-robin decides.
  - A single requester always asserting `req_valid` is served back-to-back.
- **Fairness:** with all requesters active, grants rotate 0,1,…,NUM_REQ-1,0.

## Structure
- Package `alu_arb_pkg`:
  - State enum.
  - Op codes ADD=0, SUB=1, MUL=2, DIV=3.
  - Field slice constants for data1, data2 and op.
  - Result width 9 and packed width 10.
- One sub-module, `rr_pick`:
  - Purely combinational.
  - Inputs: request vector and `last_grant`.
  - Outputs: one-hot winner, index, and any-valid flag.
- The top level holds the FSM, operation/result latches and the timer.

## Test plan
- **Fairness:** reset, then all four requesters valid with ADD 3+4.
  - Grants go 0,1,2,3,0.
  - Each response has `rsp_data`=7 and `rsp_err`=0.
- **Multi-cycle op with backpressure:** requester 2 sends MUL 5×6; the ALU returns `alu_done` 3 cycles after accept; `rsp_ready[2]` is held low for 4 cycles.
  - `rsp_valid[2]` stays stable with `rsp_data`=30.
  - The completing handshake is followed by IDLE the next cycle.
- **Divide-by-zero:** requester 1 sends DIV 9/0.
  - `alu_valid` never rises.
  - `rsp_valid[1]` rises 1 cycle after accept with `rsp_err`=1 and `rsp_data`=0.
- **Timeout:** with TIMEOUT=15, `alu_done` is withheld.
  - Response has `rsp_err`=1 exactly 15 WAIT cycles after `alu_ready`.
  - A late `alu_done` while in RESP or IDLE is ignored.
- **Reset mid-operation:** assert `reset`=0 during WAIT.
  - All outputs take their reset values on the next edge.
  - After release, requester 0 wins first and no stale response appears.
